mem_arbiter_rr: RTL

- Parametrised N-channel arbiter between cache-line clients (I-cache, D-cache, future prefetcher/victim buffer) and a single physical-memory line port.
- Grants one channel at a time in round-robin or fixed-priority mode.
- Latches the winning request into registers, so the memory port sees stable, registered outputs for the whole transaction.
- Routes the memory response back to the granted channel only.

---
 rtl/mem_arbiter_rr.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-channel cache-line arbiter in front of a single memory line port.
// One channel is granted at a time, in round-robin or fixed-priority order. The
// winning request is registered so the memory port sees stable strobes, address
// and data for the whole transaction. The response is steered back to the
// granted channel only.

// Response steering for one channel: passes the memory line through only while
// this channel owns the grant and the response is live.
module mem_arbiter_rr_resp #(
    parameter int LINE_W = 256,
    parameter int GW     = 1,
    parameter int IDX    = 0
) (
    input  logic              resp_en,
    input  logic [GW-1:0]     grant_id,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              ch_resp,
    output logic [LINE_W-1:0] ch_rdata
);
    logic sel;

    assign sel      = resp_en && (grant_id == GW'(IDX));
    assign ch_resp  = sel;
    assign ch_rdata = sel ? mem_rdata : '0;
endmodule

module mem_arbiter_rr #(
    parameter int  NUM_CH  = 2,
    parameter int  LINE_W  = 256,
    parameter int  ADDR_W  = 32,
    parameter bit  RR_MODE = 1'b1,
    localparam int GW      = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    output logic [NUM_CH*LINE_W-1:0] ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [LINE_W-1:0]        mem_wdata,
    output logic                     mem_read,
    output logic                     mem_write,
    input  logic [LINE_W-1:0]        mem_rdata,
    input  logic                     mem_resp,
    output logic                     grant_valid,
    output logic [GW-1:0]            grant_id
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [GW-1:0]     last;
    logic [NUM_CH-1:0] req;
    logic [GW-1:0]     win;
    logic              resp_en;

    assign req     = ch_read | ch_write;
    assign resp_en = (state == BUSY) && mem_resp;

    // Winner pick: scan from last+1 in round-robin mode, from index 0 otherwise.
    always_comb begin
        int  idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx = RR_MODE ? ((int'(last) + off) % NUM_CH) : (off - 1);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
    end

    // Grant FSM: latch the winner in IDLE, hold it in BUSY until mem_resp,
    // then spend one dead cycle in DONE so clients can drop their strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            last        <= GW'(NUM_CH - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        mem_address <= ch_address[win*ADDR_W +: ADDR_W];
                        mem_wdata   <= ch_wdata[win*LINE_W +: LINE_W];
                        // a write takes precedence when both strobes are up
                        mem_write   <= ch_write[win];
                        mem_read    <= ch_read[win] & ~ch_write[win];
                        grant_id    <= win;
                        grant_valid <= 1'b1;
                        if (RR_MODE) last <= win;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        grant_valid <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mem_arbiter_rr_resp #(
            .LINE_W (LINE_W),
            .GW     (GW),
            .IDX    (i)
        ) u_resp (
            .resp_en   (resp_en),
            .grant_id  (grant_id),
            .mem_rdata (mem_rdata),
            .ch_resp   (ch_resp[i]),
            .ch_rdata  (ch_rdata[i*LINE_W +: LINE_W])
        );
    end
endmodule
